// File: rtl/xadac_dotp_unit.sv
// xadac accelerator endpoint: decode responder, execute-request FIFO and a
// multi-cycle 4x8-bit signed/unsigned dot product with optional accumulate.
module xadac_dotp_unit #(
    parameter int unsigned FifoDepth     = 4,
    parameter int unsigned BytesPerCycle = 1,
    parameter int unsigned IdWidth       = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [IdWidth-1:0] slv_dec_req_id,
    input  logic [31:0]        slv_dec_req_instr,
    input  logic               slv_dec_req_valid,
    output logic               slv_dec_req_ready,
    output logic [IdWidth-1:0] slv_dec_rsp_id,
    output logic [1:0]         slv_dec_rsp_rs_read,
    output logic               slv_dec_rsp_rd_clobber,
    output logic               slv_dec_rsp_valid,
    input  logic               slv_dec_rsp_ready,
    input  logic [IdWidth-1:0] slv_exe_req_id,
    input  logic [31:0]        slv_exe_req_instr,
    input  logic [31:0]        slv_exe_req_rs0,
    input  logic [31:0]        slv_exe_req_rs1,
    input  logic               slv_exe_req_valid,
    output logic               slv_exe_req_ready,
    output logic [IdWidth-1:0] slv_exe_rsp_id,
    output logic [4:0]         slv_exe_rsp_rd,
    output logic [31:0]        slv_exe_rsp_data,
    output logic               slv_exe_rsp_valid,
    input  logic               slv_exe_rsp_ready
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, MAC, RSP} state_e;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    // Holds every ready low from reset release until the first clock edge.
    logic active_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) active_q <= 1'b0;
        else       active_q <= 1'b1;
    end

    logic dec_fire;

    assign slv_dec_req_ready = active_q & (~slv_dec_rsp_valid | slv_dec_rsp_ready);
    assign dec_fire          = slv_dec_req_valid & slv_dec_req_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slv_dec_rsp_valid      <= 1'b0;
            slv_dec_rsp_id         <= '0;
            slv_dec_rsp_rs_read    <= '0;
            slv_dec_rsp_rd_clobber <= 1'b0;
        end else if (dec_fire) begin
            slv_dec_rsp_valid      <= 1'b1;
            slv_dec_rsp_id         <= slv_dec_req_id;
            slv_dec_rsp_rs_read    <= 2'b11;
            slv_dec_rsp_rd_clobber <= 1'b1;
        end else if (slv_dec_rsp_ready) begin
            slv_dec_rsp_valid      <= 1'b0;
        end
    end

    // Queue entry keeps only instr[13:7]: accumulate, signed, rd.
    logic [IdWidth-1:0] fifo_id  [FifoDepth];
    logic [6:0]         fifo_op  [FifoDepth];
    logic [31:0]        fifo_rs0 [FifoDepth];
    logic [31:0]        fifo_rs1 [FifoDepth];
    logic [PtrW-1:0]    wr_ptr, rd_ptr;
    logic [CntW-1:0]    count;
    logic               push, pop;

    assign slv_exe_req_ready = active_q & (count != CntFull);
    assign push              = slv_exe_req_valid & slv_exe_req_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= slv_exe_req_id;
            fifo_op[wr_ptr]  <= slv_exe_req_instr[13:7];
            fifo_rs0[wr_ptr] <= slv_exe_req_rs0;
            fifo_rs1[wr_ptr] <= slv_exe_req_rs1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    state_e       state_q, state_d;
    logic [31:0]  op_a_q, op_b_q, partial_q, acc_q, mac_sum, final_sum;
    logic         op_signed_q, op_acc_q, last_lane;
    logic [1:0]   cnt_q;
    logic [IdWidth-1:0] rsp_id_q;
    logic [4:0]   rsp_rd_q;
    logic [31:0]  rsp_data_q;

    assign last_lane = (32'(cnt_q) + BytesPerCycle == 32'd4);

    always_comb begin
        mac_sum = partial_q;
        for (int unsigned j = 0; j < BytesPerCycle; j++) begin
            mac_sum = mac_sum
                    + ext8(op_a_q[{cnt_q + 2'(j), 3'b000} +: 8], op_signed_q)
                    * ext8(op_b_q[{cnt_q + 2'(j), 3'b000} +: 8], op_signed_q);
        end
        final_sum = mac_sum + (op_acc_q ? acc_q : '0);
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (count != '0) begin
                pop     = 1'b1;
                state_d = MAC;
            end
            MAC:  if (last_lane) state_d = RSP;
            RSP:  if (slv_exe_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_signed_q <= 1'b0;
            op_acc_q    <= 1'b0;
            cnt_q       <= '0;
            partial_q   <= '0;
            acc_q       <= '0;
            rsp_id_q    <= '0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (pop) begin
                    op_a_q      <= fifo_rs0[rd_ptr];
                    op_b_q      <= fifo_rs1[rd_ptr];
                    op_acc_q    <= fifo_op[rd_ptr][6];
                    op_signed_q <= fifo_op[rd_ptr][5];
                    rsp_rd_q    <= fifo_op[rd_ptr][4:0];
                    rsp_id_q    <= fifo_id[rd_ptr];
                    partial_q   <= '0;
                    cnt_q       <= '0;
                end
                MAC: begin
                    partial_q <= mac_sum;
                    cnt_q     <= cnt_q + 2'(BytesPerCycle);
                    if (last_lane) begin
                        rsp_data_q <= final_sum;
                        acc_q      <= final_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slv_exe_rsp_valid = (state_q == RSP);
    assign slv_exe_rsp_id    = rsp_id_q;
    assign slv_exe_rsp_rd    = rsp_rd_q;
    assign slv_exe_rsp_data  = rsp_data_q;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{slv_dec_req_instr, slv_exe_req_instr[31:14], slv_exe_req_instr[6:0]};

endmodule

// File: tb/tb_xadac_dotp_unit.sv
// Randomized self-checking bench for xadac_dotp_unit against a byte-lane
// arithmetic reference model with an ordered response queue.
module tb_xadac_dotp_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  slv_dec_req_id;
    logic [31:0] slv_dec_req_instr;
    logic        slv_dec_req_valid;
    logic        slv_dec_req_ready;
    logic [3:0]  slv_dec_rsp_id;
    logic [1:0]  slv_dec_rsp_rs_read;
    logic        slv_dec_rsp_rd_clobber;
    logic        slv_dec_rsp_valid;
    logic        slv_dec_rsp_ready;
    logic [3:0]  slv_exe_req_id;
    logic [31:0] slv_exe_req_instr;
    logic [31:0] slv_exe_req_rs0;
    logic [31:0] slv_exe_req_rs1;
    logic        slv_exe_req_valid;
    logic        slv_exe_req_ready;
    logic [3:0]  slv_exe_rsp_id;
    logic [4:0]  slv_exe_rsp_rd;
    logic [31:0] slv_exe_rsp_data;
    logic        slv_exe_rsp_valid;
    logic        slv_exe_rsp_ready;

    always #5 clk = ~clk;

    xadac_dotp_unit #(.FifoDepth(4), .BytesPerCycle(1), .IdWidth(4)) dut (
        .clk(clk), .rstn(rstn),
        .slv_dec_req_id(slv_dec_req_id), .slv_dec_req_instr(slv_dec_req_instr),
        .slv_dec_req_valid(slv_dec_req_valid), .slv_dec_req_ready(slv_dec_req_ready),
        .slv_dec_rsp_id(slv_dec_rsp_id), .slv_dec_rsp_rs_read(slv_dec_rsp_rs_read),
        .slv_dec_rsp_rd_clobber(slv_dec_rsp_rd_clobber), .slv_dec_rsp_valid(slv_dec_rsp_valid),
        .slv_dec_rsp_ready(slv_dec_rsp_ready),
        .slv_exe_req_id(slv_exe_req_id), .slv_exe_req_instr(slv_exe_req_instr),
        .slv_exe_req_rs0(slv_exe_req_rs0), .slv_exe_req_rs1(slv_exe_req_rs1),
        .slv_exe_req_valid(slv_exe_req_valid), .slv_exe_req_ready(slv_exe_req_ready),
        .slv_exe_rsp_id(slv_exe_rsp_id), .slv_exe_rsp_rd(slv_exe_rsp_rd),
        .slv_exe_rsp_data(slv_exe_rsp_data), .slv_exe_rsp_valid(slv_exe_rsp_valid),
        .slv_exe_rsp_ready(slv_exe_rsp_ready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    int          passed = 0;
    int          total  = 0;
    exp_t        exp_q[$];
    logic [31:0] model_acc = '0;

    function automatic logic [31:0] ref_dot(input logic sgn, input logic acc_en,
                                            input logic [31:0] rs0, input logic [31:0] rs1,
                                            input logic [31:0] acc);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            longint a = longint'((rs0 >> (8 * i)) & 32'hFF);
            longint b = longint'((rs1 >> (8 * i)) & 32'hFF);
            if (sgn && a > 127) a = a - 256;
            if (sgn && b > 127) b = b - 256;
            s = s + a * b;
        end
        if (acc_en) s = s + longint'(acc);
        return 32'(s);
    endfunction

    task automatic model_push(input logic [3:0] id, input logic [31:0] instr,
                              input logic [31:0] rs0, input logic [31:0] rs1);
        exp_t e;
        e.id      = id;
        e.rd      = instr[11:7];
        e.data    = ref_dot(instr[12], instr[13], rs0, rs1, model_acc);
        model_acc = e.data;
        exp_q.push_back(e);
    endtask

    task automatic push_op(input logic [3:0] id, input logic [31:0] instr,
                           input logic [31:0] rs0, input logic [31:0] rs1);
        int n = 0;
        slv_exe_req_id    = id;
        slv_exe_req_instr = instr;
        slv_exe_req_rs0   = rs0;
        slv_exe_req_rs1   = rs1;
        slv_exe_req_valid = 1'b1;
        while (!slv_exe_req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL push_timeout: exe_req_ready=%b required 1", slv_exe_req_ready);
            slv_exe_req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        slv_exe_req_valid = 1'b0;
        model_push(id, instr, rs0, rs1);
    endtask

    task automatic get_rsp(output exp_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        slv_exe_rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (slv_exe_rsp_valid) begin
                r.id   = slv_exe_rsp_id;
                r.rd   = slv_exe_rsp_rd;
                r.data = slv_exe_rsp_data;
                ok     = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        slv_exe_rsp_ready = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL rsp_timeout: exe_rsp_valid=%b required 1", slv_exe_rsp_valid);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({slv_dec_req_ready, slv_exe_req_ready, slv_dec_rsp_valid, slv_exe_rsp_valid} !== 4'b0000)
            $display("FAIL reset_valids: got %b required 0000",
                     {slv_dec_req_ready, slv_exe_req_ready, slv_dec_rsp_valid, slv_exe_rsp_valid});
        else passed++;
        total++;
        if ({slv_dec_rsp_id, slv_dec_rsp_rs_read, slv_dec_rsp_rd_clobber,
             slv_exe_rsp_id, slv_exe_rsp_rd, slv_exe_rsp_data} !== '0)
            $display("FAIL reset_payload: dec_id=%h rs_read=%b exe_data=%h required zeros",
                     slv_dec_rsp_id, slv_dec_rsp_rs_read, slv_exe_rsp_data);
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        total++;
        if ({slv_dec_req_ready, slv_exe_req_ready} !== 2'b00)
            $display("FAIL ready_before_first_edge: got %b required 00", {slv_dec_req_ready, slv_exe_req_ready});
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({slv_dec_req_ready, slv_exe_req_ready} !== 2'b11)
            $display("FAIL ready_after_first_edge: got %b required 11", {slv_dec_req_ready, slv_exe_req_ready});
        else passed++;
    endtask

    task automatic test_decode();
        slv_dec_rsp_ready = 1'b1;
        slv_dec_req_id    = 4'd3;
        slv_dec_req_instr = $urandom;
        slv_dec_req_valid = 1'b1;
        @(posedge clk); #1;
        slv_dec_req_valid = 1'b0;
        total++;
        if ({slv_dec_rsp_valid, slv_dec_rsp_id, slv_dec_rsp_rs_read, slv_dec_rsp_rd_clobber} !== {1'b1, 4'd3, 2'b11, 1'b1})
            $display("FAIL decode_single: valid=%b id=%0d rs_read=%b clobber=%b required 1 3 11 1",
                     slv_dec_rsp_valid, slv_dec_rsp_id, slv_dec_rsp_rs_read, slv_dec_rsp_rd_clobber);
        else passed++;
        for (int k = 5; k < 8; k++) begin
            slv_dec_req_id    = 4'(k);
            slv_dec_req_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({slv_dec_rsp_valid, slv_dec_rsp_id} !== {1'b1, 4'(k)})
                $display("FAIL decode_b2b: valid=%b id=%0d required 1 %0d", slv_dec_rsp_valid, slv_dec_rsp_id, k);
            else passed++;
        end
        slv_dec_req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (slv_dec_rsp_valid !== 1'b0)
            $display("FAIL decode_drain: valid=%b required 0", slv_dec_rsp_valid);
        else passed++;
        slv_dec_rsp_ready = 1'b0;
        slv_dec_req_id    = 4'd9;
        slv_dec_req_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({slv_dec_rsp_valid, slv_dec_rsp_id, slv_dec_req_ready} !== {1'b1, 4'd9, 1'b0})
            $display("FAIL decode_stall: valid=%b id=%0d req_ready=%b required 1 9 0",
                     slv_dec_rsp_valid, slv_dec_rsp_id, slv_dec_req_ready);
        else passed++;
        slv_dec_req_valid = 1'b0;
        slv_dec_rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_latency();
        exp_t e;
        slv_exe_rsp_ready = 1'b0;
        slv_exe_req_id    = 4'd6;
        slv_exe_req_instr = 32'd5 << 7;
        slv_exe_req_rs0   = 32'h04030201;
        slv_exe_req_rs1   = 32'h01010101;
        slv_exe_req_valid = 1'b1;
        @(posedge clk); #1;
        slv_exe_req_valid = 1'b0;
        model_push(4'd6, 32'd5 << 7, 32'h04030201, 32'h01010101);
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                total++;
                if (slv_exe_rsp_valid !== 1'b0) $display("FAIL latency_early: valid=%b required 0 at edge 5", slv_exe_rsp_valid);
                else passed++;
            end
        end
        total++;
        if (slv_exe_rsp_valid !== 1'b1) $display("FAIL latency_6: valid=%b required 1 at edge 6", slv_exe_rsp_valid);
        else passed++;
        e = exp_q.pop_front();
        total++;
        if ({slv_exe_rsp_id, slv_exe_rsp_rd, slv_exe_rsp_data} !== {4'd6, 5'd5, 32'h0000000A})
            $display("FAIL unsigned_dot: id=%0d rd=%0d data=%h required 6 5 0000000a",
                     slv_exe_rsp_id, slv_exe_rsp_rd, slv_exe_rsp_data);
        else passed++;
        total++;
        if (slv_exe_rsp_data !== e.data) $display("FAIL unsigned_model: data=%h required %h", slv_exe_rsp_data, e.data);
        else passed++;
        slv_exe_rsp_ready = 1'b1;
        @(posedge clk); #1;
        slv_exe_rsp_ready = 1'b0;
        total++;
        if (slv_exe_rsp_valid !== 1'b0) $display("FAIL rsp_release: valid=%b required 0", slv_exe_rsp_valid);
        else passed++;
    endtask

    task automatic test_signed_acc();
        exp_t r, e;
        bit ok;
        push_op(4'd1, 32'h1000 | (32'd3 << 7), 32'h000000FF, 32'h00000002);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            total++;
            if ({r.id, r.rd, r.data} !== {4'd1, 5'd3, 32'hFFFFFFFE})
                $display("FAIL signed_dot: id=%0d rd=%0d data=%h required 1 3 fffffffe", r.id, r.rd, r.data);
            else passed++;
        end
        push_op(4'd2, 32'h3000 | (32'd4 << 7), 32'h00000001, 32'h00000003);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            total++;
            if ({r.id, r.data} !== {4'd2, 32'h00000001})
                $display("FAIL signed_accumulate: id=%0d data=%h required 2 00000001", r.id, r.data);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        exp_t r, e;
        bit ok;
        slv_exe_rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            push_op(4'(k), $urandom, $urandom, $urandom);
        slv_exe_req_id    = 4'd15;
        slv_exe_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({slv_exe_req_ready, slv_exe_rsp_valid} !== 2'b01)
                $display("FAIL full_blocks_push: req_ready=%b rsp_valid=%b required 0 1", slv_exe_req_ready, slv_exe_rsp_valid);
            else passed++;
        end
        slv_exe_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            get_rsp(r, ok);
            e = exp_q.pop_front();
            if (ok) begin
                total++;
                if (r !== e)
                    $display("FAIL backpressure_rsp%0d: id=%0d rd=%0d data=%h required %0d %0d %h",
                             k, r.id, r.rd, r.data, e.id, e.rd, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap();
        exp_t r, e;
        bit ok;
        push_op(4'd7, 32'h1000, 32'h000000FF, 32'h00000001);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            total++;
            if (r.data !== 32'hFFFFFFFF) $display("FAIL wrap_setup: data=%h required ffffffff", r.data);
            else passed++;
        end
        push_op(4'd8, 32'h2000, 32'h00000001, 32'h00000001);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            total++;
            if ({r.id, r.data} !== {4'd8, 32'h00000000}) $display("FAIL wrap_result: id=%0d data=%h required 8 00000000", r.id, r.data);
            else passed++;
        end
    endtask

    task automatic test_random();
        localparam int N = 24;
        fork
            begin
                for (int k = 0; k < N; k++) begin
                    logic [31:0] a = $urandom;
                    logic [31:0] b = $urandom;
                    if (k % 5 == 0) a = 32'h80FF7F01;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #0;
                    push_op(4'($urandom_range(0, 15)), $urandom, a, b);
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                while (got < N && cyc < 3000) begin
                    slv_exe_rsp_ready = ($urandom_range(0, 3) != 0);
                    if (slv_exe_rsp_valid && slv_exe_rsp_ready) begin
                        exp_t e;
                        total++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL random_unexpected: data=%h with no pending op", slv_exe_rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            if ({slv_exe_rsp_id, slv_exe_rsp_rd, slv_exe_rsp_data} !== e)
                                $display("FAIL random_rsp%0d: id=%0d rd=%0d data=%h required %0d %0d %h",
                                         got, slv_exe_rsp_id, slv_exe_rsp_rd, slv_exe_rsp_data, e.id, e.rd, e.data);
                            else passed++;
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                slv_exe_rsp_ready = 1'b0;
                if (got < N) begin
                    total++;
                    $display("FAIL random_timeout: got %0d responses required %0d", got, N);
                end
            end
        join
    endtask

    task automatic test_reset_midflight();
        exp_t r, e;
        bit ok;
        int seen = 0;
        slv_exe_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            push_op(4'(k + 10), $urandom, $urandom, $urandom);
        exp_q.delete();
        model_acc = '0;
        rstn = 1'b0;
        #2;
        total++;
        if ({slv_exe_rsp_valid, slv_exe_req_ready, slv_dec_req_ready, slv_dec_rsp_valid} !== 4'b0000)
            $display("FAIL midflight_reset: got %b required 0000",
                     {slv_exe_rsp_valid, slv_exe_req_ready, slv_dec_req_ready, slv_dec_rsp_valid});
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        slv_exe_rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (slv_exe_rsp_valid) seen++;
        end
        slv_exe_rsp_ready = 1'b0;
        total++;
        if (seen != 0) $display("FAIL flushed_ops: %0d response cycles required 0", seen);
        else passed++;
        push_op(4'd4, 32'h2000, 32'h00000002, 32'h00000003);
        get_rsp(r, ok);
        e = exp_q.pop_front();
        if (ok) begin
            total++;
            if ({r.id, r.data} !== {4'd4, 32'h00000006})
                $display("FAIL acc_cleared: id=%0d data=%h required 4 00000006", r.id, r.data);
            else passed++;
        end
    endtask

    initial begin
        slv_dec_req_id    = '0;
        slv_dec_req_instr = '0;
        slv_dec_req_valid = 1'b0;
        slv_dec_rsp_ready = 1'b0;
        slv_exe_req_id    = '0;
        slv_exe_req_instr = '0;
        slv_exe_req_rs0   = '0;
        slv_exe_req_rs1   = '0;
        slv_exe_req_valid = 1'b0;
        slv_exe_rsp_ready = 1'b0;
        test_reset();
        test_decode();
        test_unsigned_latency();
        test_signed_acc();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
